// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand loader: byte width and FSM state encoding.
package rsa_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_M = 3'd1,
      LOAD_E = 3'd2,
      LOAD_N = 3'd3,
      CHECK  = 3'd4,
      START  = 3'd5,
      WAIT   = 3'd6
   } state_e;

endpackage

// File: rtl/byte_shreg.sv
// LSB-first byte assembler: each loaded byte enters at the top and shifts down,
// so after WIDTH/8 loads the first byte sits in the least-significant position.
module byte_shreg
   import rsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              load_i,
   input  logic [BYTE_W-1:0] din_i,
   output logic [WIDTH-1:0]  q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   generate
      if (WIDTH == BYTE_W) begin : g_single
         always_comb q_d = load_i ? din_i : q_q;
      end else begin : g_multi
         always_comb q_d = load_i ? {din_i, q_q[WIDTH-1:BYTE_W]} : q_q;
      end
   endgenerate

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/operand_loader.sv
// Streams M, E and N (LSB byte first) into operand registers and launches the crypt core.
// Optional operand sanity check enabled by defining OPERAND_LOADER_CHECK_EN.
module operand_loader
   import rsa_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              en,
   input  logic [BYTE_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   input  logic              eoc,
   output logic [WIDTH-1:0]  M_o,
   output logic [WIDTH-1:0]  E_o,
   output logic [WIDTH-1:0]  N_o,
   output logic              start,
   output logic              busy,
   output logic              err
);

   localparam int NBYTES = WIDTH / BYTE_W;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc;
   logic             last;
   logic             ld_m, ld_e, ld_n;

   assign din_ready = rstb & ((state_q == IDLE) || (state_q == LOAD_M) ||
                              (state_q == LOAD_E) || (state_q == LOAD_N));
   assign acc  = en & din_valid & din_ready;
   assign last = (cnt_q == CNT_W'(NBYTES - 1));

   // A byte taken in IDLE is M byte 0 and restarts the M register fill.
   assign ld_m = acc & ((state_q == IDLE) || (state_q == LOAD_M));
   assign ld_e = acc & (state_q == LOAD_E);
   assign ld_n = acc & (state_q == LOAD_N);

`ifdef OPERAND_LOADER_CHECK_EN
   logic err_q, err_d;
   logic bad_op;

   // N == 0 is already even; listed separately to keep the intent readable.
   assign bad_op = (N_o == '0) | ~N_o[0] | (M_o >= N_o);
   assign err    = err_q;
`else
   assign err    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef OPERAND_LOADER_CHECK_EN
      err_d   = err_q;
`endif
      if (acc) cnt_d = last ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
         IDLE: begin
            if (acc) begin
               state_d = last ? LOAD_E : LOAD_M;
`ifdef OPERAND_LOADER_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         LOAD_M: if (acc && last) state_d = LOAD_E;
         LOAD_E: if (acc && last) state_d = LOAD_N;
         LOAD_N: if (acc && last) state_d = CHECK;
         CHECK: begin
            if (en) begin
`ifdef OPERAND_LOADER_CHECK_EN
               if (bad_op) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = START;
               end
`else
               state_d = START;
`endif
            end
         end
         START:   if (en) state_d = WAIT;
         WAIT:    if (en && eoc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q <= IDLE;
         cnt_q   <= '0;
`ifdef OPERAND_LOADER_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
`ifdef OPERAND_LOADER_CHECK_EN
         err_q   <= err_d;
`endif
      end
   end

   assign start = (state_q == START);
   assign busy  = (state_q != IDLE);

   byte_shreg #(.WIDTH(WIDTH)) u_m (
      .clk(clk), .rstb(rstb), .load_i(ld_m), .din_i(din), .q_o(M_o)
   );
   byte_shreg #(.WIDTH(WIDTH)) u_e (
      .clk(clk), .rstb(rstb), .load_i(ld_e), .din_i(din), .q_o(E_o)
   );
   byte_shreg #(.WIDTH(WIDTH)) u_n (
      .clk(clk), .rstb(rstb), .load_i(ld_n), .din_i(din), .q_o(N_o)
   );

endmodule
